mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port memory bus between instruction fetch and data load/store (driven by
//  control/decode outputs). Grants one requester at a time and holds the grant until memory
//  completes. Data wins by default; a starvation counter forces a fetch grant. A watchdog aborts
//  hung accesses. Drives cpu_stall to freeze the PC and pipeline while any request is outstanding.
// PARAMETERS
//  ADDR_W     32  address width
//  DATA_W     32  data width; byte-enable width is DATA_W/8
//  MAX_DRUN   4   consecutive data grants allowed while fetch waits before fetch is forced
//  TIMEOUT    255 max cycles in ACCESS with mem_busy high before abort (8-bit counter)
// PORTS
//  clk        in   1         system clock, rising edge
//  rst        in   1         synchronous active-high reset
//  i_req      in   1         fetch request; held until i_ack
//  i_addr     in   ADDR_W    fetch address
//  i_ack      out  1         1-cycle pulse: fetch complete, i_rdata valid
//  i_rdata    out  DATA_W    fetched instruction (registered)
//  d_ren      in   1         data read request; held until d_ack
//  d_wen      in   1         data write request; held until d_ack
//  d_addr     in   ADDR_W    data address
//  d_wdata    in   DATA_W    store data
//  d_ben      in   DATA_W/8  store/load byte enables
//  d_ack      out  1         1-cycle pulse: data access complete, d_rdata valid on reads
//  d_rdata    out  DATA_W    load data (registered)
//  mem_ren    out  1         memory read strobe
//  mem_wen    out  1         memory write strobe
//  mem_addr   out  ADDR_W    memory address
//  mem_wdata  out  DATA_W    memory write data
//  mem_ben    out  DATA_W/8  memory byte enables
//  mem_rdata  in   DATA_W    memory read data, valid when mem_busy low during access
//  mem_busy   in   1         memory not done; access completes on first ACCESS cycle with it low
//  cpu_stall  out  1         high when any req is pending and its ack is not this cycle
//  err        out  1         sticky; set on watchdog abort, cleared only by rst
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (acks, rdata regs, mem_* strobes/addr/wdata/ben, err);
//   drun_cnt=0, wd_cnt=0.
//  States: IDLE, ACCESS (grant owner in reg owner: I or D), DONE.
//  IDLE: d_req = d_ren|d_wen. If d_req && !(i_req && drun_cnt==MAX_DRUN) -> owner=D; else if i_req
//   -> owner=I; else stay. On grant, latch addr/wdata/ben/op into mem_* regs; next state ACCESS.
//   A requester whose ack is high this cycle is masked from arbitration (no re-grant same cycle).
//  d_ren && d_wen together: treated as write.
//  ACCESS: mem_ren/mem_wen asserted per latched op (fetch always read, ben=all ones). Address and
//   data stay stable for the whole ACCESS. If mem_busy==0: capture mem_rdata into owner's rdata reg,
//   drop strobes, go DONE. Else wd_cnt++; if wd_cnt reaches TIMEOUT: drop strobes, set err, go DONE
//   (rdata reg <= 0).
//  DONE: pulse owner's ack exactly one cycle; wd_cnt=0; next state IDLE. Strobes low.
//  Latency: req seen at cycle t, mem_busy low in first ACCESS cycle -> ack at t+2; each extra
//   busy cycle adds one.
//  Starvation: drun_cnt++ on each data grant while i_req high (saturates at MAX_DRUN); cleared on
//   any fetch grant or whenever i_req low in IDLE.
//  Requester dropping req mid-access: access still completes; ack still pulses (ignored upstream).
//  Latched values ignore input changes after grant.
//  rst asserted mid-ACCESS: next cycle strobes low, state IDLE, no ack issued, err cleared.
//  cpu_stall = (i_req & ~i_ack) | (d_req & ~d_ack), combinational from regs and inputs.
// TESTING
//  Fetch only: i_req=1, i_addr=0x100, mem_busy=0, mem_rdata=0x00C50C33 -> mem_ren@t+1, i_ack@t+2,
//   i_rdata=0x00C50C33, stall high t..t+1.
//  Simultaneous i_req+d_wen (d_addr=0x2000, wdata=0xDEADBEEF, ben=0xF) -> data granted first,
//   mem_wen with those values, d_ack, then fetch granted; i_ack 3 cycles after d_ack.
//  Starvation: d_ren held continuously with i_req, MAX_DRUN=4 -> 4 d_acks, then fetch granted.
//  Wait states: mem_busy high 3 cycles of ACCESS -> ack at t+5; mem_addr stable throughout.
//  Watchdog: TIMEOUT=8, mem_busy stuck 1 -> strobes drop after 8 busy cycles, err=1, ack pulses,
//   rdata=0; err stays 1 until rst.
//  Reset mid-ACCESS: rst during busy -> next cycle all outputs 0, state IDLE, no ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory bus arbiter between instruction fetch and data load/store.
// Data wins by default; a starvation counter forces fetch, a watchdog aborts hung accesses.
module mem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_DRUN = 4,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_ack,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_ren,
    input  logic                  d_wen,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_ben,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_ben,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_busy,
    output logic                  cpu_stall,
    output logic                  err
);
    localparam int unsigned BEN_W  = DATA_W / 8;
    localparam int unsigned DRUN_W = $clog2(MAX_DRUN + 1);
    localparam int unsigned WD_W   = 8;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [DRUN_W-1:0]   drun_q, drun_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                i_ack_q, i_ack_d, d_ack_q, d_ack_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic                mem_ren_q, mem_ren_d, mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BEN_W-1:0]    mem_ben_q, mem_ben_d;
    logic                err_q, err_d;

    logic d_req, d_can, i_can, starved;

    assign d_req   = d_ren | d_wen;
    // A requester being acked this cycle may not win the bus again in the same cycle.
    assign d_can   = d_req & ~d_ack_q;
    assign i_can   = i_req & ~i_ack_q;
    assign starved = i_can & (drun_q == DRUN_W'(MAX_DRUN));

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        drun_d      = drun_q;
        wd_d        = wd_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_ren_d   = mem_ren_q;
        mem_wen_d   = mem_wen_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_ben_d   = mem_ben_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (!i_req) drun_d = '0;
                if (d_can && !starved) begin
                    owner_d     = OWN_D;
                    mem_wen_d   = d_wen;
                    mem_ren_d   = ~d_wen;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_ben_d   = d_ben;
                    if (i_req && drun_q != DRUN_W'(MAX_DRUN)) drun_d = drun_q + DRUN_W'(1);
                    state_d     = S_ACCESS;
                end else if (i_can) begin
                    owner_d     = OWN_I;
                    mem_ren_d   = 1'b1;
                    mem_wen_d   = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    mem_ben_d   = '1;
                    drun_d      = '0;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!mem_busy) begin
                    mem_ren_d = 1'b0;
                    mem_wen_d = 1'b0;
                    if (owner_q == OWN_D) begin
                        d_rdata_d = mem_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        i_rdata_d = mem_rdata;
                        i_ack_d   = 1'b1;
                    end
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    if (wd_d == WD_W'(TIMEOUT)) begin
                        mem_ren_d = 1'b0;
                        mem_wen_d = 1'b0;
                        err_d     = 1'b1;
                        if (owner_q == OWN_D) begin
                            d_rdata_d = '0;
                            d_ack_d   = 1'b1;
                        end else begin
                            i_rdata_d = '0;
                            i_ack_d   = 1'b1;
                        end
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                wd_d    = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_I;
            drun_q      <= '0;
            wd_q        <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_ben_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            drun_q      <= drun_d;
            wd_q        <= wd_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_ren_q   <= mem_ren_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_ben_q   <= mem_ben_d;
            err_q       <= err_d;
        end
    end

    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_ren   = mem_ren_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_ben   = mem_ben_q;
    assign err       = err_q;
    assign cpu_stall = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority, starvation, wait states, watchdog, reset.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_ack;
    logic [31:0] i_addr, i_rdata;
    logic        d_ren, d_wen, d_ack;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_ben;
    logic        mem_ren, mem_wen, mem_busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_ben;
    logic        cpu_stall, err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DRUN(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_ben(d_ben),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ben(mem_ben), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
        .cpu_stall(cpu_stall), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; i_req = 0; i_addr = '0; d_ren = 0; d_wen = 0; d_addr = '0;
        d_wdata = '0; d_ben = '0; mem_busy = 0; mem_rdata = '0;
        step(); step();
        chk("rst_i_ack", i_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_mem_ren", mem_ren, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_ben", mem_ben, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        step();

        // Fetch only
        i_req = 1; i_addr = 32'h100; mem_busy = 0; mem_rdata = 32'h00C50C33;
        #1 chk("f_stall_t", cpu_stall, 1);
        step();
        chk("f_mem_ren", mem_ren, 1);
        chk("f_mem_wen", mem_wen, 0);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_ben", mem_ben, 4'hF);
        chk("f_stall_t1", cpu_stall, 1);
        chk("f_no_ack_t1", i_ack, 0);
        step();
        chk("f_i_ack", i_ack, 1);
        chk("f_i_rdata", i_rdata, 32'h00C50C33);
        chk("f_stall_t2", cpu_stall, 0);
        chk("f_ren_drop", mem_ren, 0);
        i_req = 0;
        step();
        chk("f_ack_pulse", i_ack, 0);

        // Simultaneous fetch and write: data first, fetch three cycles after d_ack
        i_req = 1; i_addr = 32'h104; d_wen = 1; d_addr = 32'h2000;
        d_wdata = 32'hDEADBEEF; d_ben = 4'hF; mem_rdata = 32'h11112222;
        step();
        chk("s_mem_wen", mem_wen, 1);
        chk("s_mem_ren", mem_ren, 0);
        chk("s_mem_addr", mem_addr, 32'h2000);
        chk("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("s_mem_ben", mem_ben, 4'hF);
        step();
        chk("s_d_ack", d_ack, 1);
        chk("s_i_ack0", i_ack, 0);
        chk("s_stall", cpu_stall, 1);
        d_wen = 0;
        step();
        chk("s_idle_ren", mem_ren, 0);
        step();
        chk("s_f_ren", mem_ren, 1);
        chk("s_f_addr", mem_addr, 32'h104);
        step();
        chk("s_i_ack", i_ack, 1);
        chk("s_i_rdata", i_rdata, 32'h11112222);
        i_req = 0;
        step();

        // Starvation: four data grants then a forced fetch
        i_req = 1; i_addr = 32'h200; d_ren = 1; d_addr = 32'h3000; d_ben = 4'h3;
        mem_rdata = 32'hA5A5A5A5;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("sv_d_ren", mem_ren, 1);
            chk("sv_d_addr", mem_addr, 32'h3000);
            chk("sv_d_ben", mem_ben, 4'h3);
            step();
            chk("sv_d_ack", d_ack, 1);
            chk("sv_d_rdata", d_rdata, 32'hA5A5A5A5);
            step();
        end
        step();
        chk("sv_f_addr", mem_addr, 32'h200);
        chk("sv_f_ben", mem_ben, 4'hF);
        step();
        chk("sv_i_ack", i_ack, 1);
        chk("sv_no_d_ack", d_ack, 0);
        i_req = 0; d_ren = 0;
        step();

        // Wait states: three busy cycles, latched address ignores input changes
        d_ren = 1; d_addr = 32'h4000; d_ben = 4'hF; mem_busy = 1; mem_rdata = 32'h12345678;
        step();
        chk("w_ren", mem_ren, 1);
        chk("w_addr1", mem_addr, 32'h4000);
        d_addr = 32'h9999;
        step();
        chk("w_addr2", mem_addr, 32'h4000);
        chk("w_no_ack2", d_ack, 0);
        step();
        chk("w_addr3", mem_addr, 32'h4000);
        step();
        chk("w_addr4", mem_addr, 32'h4000);
        chk("w_no_ack4", d_ack, 0);
        chk("w_stall4", cpu_stall, 1);
        mem_busy = 0;
        step();
        chk("w_d_ack", d_ack, 1);
        chk("w_d_rdata", d_rdata, 32'h12345678);
        d_ren = 0;
        step();

        // Watchdog: memory stuck busy
        i_req = 1; i_addr = 32'h500; mem_busy = 1; mem_rdata = 32'hFFFFFFFF;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("wd_ren_held", mem_ren, 1);
            chk("wd_err_low", err, 0);
        end
        step();
        chk("wd_ren_drop", mem_ren, 0);
        chk("wd_err", err, 1);
        chk("wd_i_ack", i_ack, 1);
        chk("wd_i_rdata", i_rdata, 0);
        i_req = 0; mem_busy = 0;
        step();
        chk("wd_err_sticky", err, 1);
        chk("wd_ack_pulse", i_ack, 0);

        // Reset in the middle of an access
        d_wen = 1; d_addr = 32'h6000; d_wdata = 32'h55; d_ben = 4'hF; mem_busy = 1;
        step();
        chk("r_mem_wen", mem_wen, 1);
        chk("r_err_before", err, 1);
        step();
        rst = 1;
        step();
        chk("r_mem_wen0", mem_wen, 0);
        chk("r_mem_addr0", mem_addr, 0);
        chk("r_err0", err, 0);
        chk("r_d_rdata0", d_rdata, 0);
        chk("r_d_ack0", d_ack, 0);
        rst = 0; d_wen = 0; mem_busy = 0;
        step();
        chk("r_no_ack1", d_ack, 0);
        chk("r_idle_wen", mem_wen, 0);
        step();
        chk("r_no_ack2", d_ack, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
